// File: rtl/mini_cpu_pkg.sv
// Shared mini-CPU definitions: operation enum and RV64 opcode/funct fields used by
// both the control decoder and the program loader (instr_encoder).
package mini_cpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_LD  = 3'd4,
        OP_SD  = 3'd5,
        OP_BEQ = 3'd6,
        OP_ILL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_LD      = 3'b011;
    localparam logic [2:0] FUNCT3_SD      = 3'b011;
    localparam logic [2:0] FUNCT3_BEQ     = 3'b000;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

endpackage

// File: rtl/instr_encoder_if.sv
// Request stream (operations in) and imem write port (encoded words out) of instr_encoder.
// slave = encoder side, master = producer/imem side.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [12:0]       req_imm;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, wr_ready,
        output req_ready, wr_valid, wr_addr, wr_data
    );

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, wr_ready,
        input  req_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encode_fmt.sv
// Combinational op/regs/imm -> 32-bit RV64 instruction word, plus illegal/imm_bad flags.
// Immediate range checking exists only when ENCODER_IMM_CHECK_EN is defined.
module instr_encode_fmt
    import mini_cpu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        imm_bad
);

    op_t op_s;
    assign op_s = op_t'(op);

    // Instruction word assembly for each supported format.
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (op_s)
            OP_ADD:  word = {FUNCT7_BASE, rs2, rs1, FUNCT3_ADD_SUB, rd, OPCODE_OP};
            OP_SUB:  word = {FUNCT7_SUB,  rs2, rs1, FUNCT3_ADD_SUB, rd, OPCODE_OP};
            OP_AND:  word = {FUNCT7_BASE, rs2, rs1, FUNCT3_AND,     rd, OPCODE_OP};
            OP_OR:   word = {FUNCT7_BASE, rs2, rs1, FUNCT3_OR,      rd, OPCODE_OP};
            OP_LD:   word = {imm[11:0], rs1, FUNCT3_LD, rd, OPCODE_LOAD};
            OP_SD:   word = {imm[11:5], rs2, rs1, FUNCT3_SD, imm[4:0], OPCODE_STORE};
            OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, FUNCT3_BEQ,
                             imm[4:1], imm[11], OPCODE_BRANCH};
            default: illegal = 1'b1;
        endcase
    end

`ifdef ENCODER_IMM_CHECK_EN
    // A 13-bit value fits the 12-bit signed range only if its top two bits agree.
    always_comb begin
        imm_bad = 1'b0;
        case (op_s)
            OP_LD, OP_SD: imm_bad = (imm[12] != imm[11]);
            OP_BEQ:       imm_bad = imm[0];
            default:      imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes a stream of mini-CPU operations into RV64 words written to
// consecutive imem addresses. Optional immediate checking: ENCODER_IMM_CHECK_EN.
module instr_encoder
    import mini_cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err_illegal,
    output logic              err_imm
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    enc_state_t        state_r;
    enc_state_t        state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   acc_r;
    logic              wr_valid_r;
    logic [31:0]       wr_data_r;
    logic              err_ill_r;

    logic [31:0]       word_s;
    logic              illegal_s;
    logic              imm_bad_s;
    logic              req_ready_s;
    logic              accept_s;
    logic              keep_s;
    logic              drain_s;
    logic              last_s;
    logic              start_s;

    instr_encode_fmt u_fmt (
        .op      (bus.req_op),
        .rd      (bus.req_rd),
        .rs1     (bus.req_rs1),
        .rs2     (bus.req_rs2),
        .imm     (bus.req_imm),
        .word    (word_s),
        .illegal (illegal_s),
        .imm_bad (imm_bad_s)
    );

    // The output register may be refilled in the same cycle it is drained.
    assign req_ready_s = (state_r == ST_RUN) && (!wr_valid_r || bus.wr_ready) &&
                         (acc_r < DEPTH_C);
    assign accept_s    = bus.req_valid && req_ready_s;
    assign keep_s      = accept_s && !illegal_s && !imm_bad_s;
    assign drain_s     = wr_valid_r && bus.wr_ready;
    assign last_s      = accept_s && (acc_r == (DEPTH_C - ONE_C));
    assign start_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // Session FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_s = ST_RUN;
                else       state_s = state_r;
            end
            ST_RUN: begin
                if (finish || last_s) state_s = ST_DRAIN;
                else                  state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!wr_valid_r) state_s = ST_DONE;
                else             state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Session FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Output register, write address, counters and sticky illegal-op flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= '0;
            count_r    <= '0;
            acc_r      <= '0;
            wr_valid_r <= 1'b0;
            wr_data_r  <= 32'h0000_0000;
            err_ill_r  <= 1'b0;
        end else begin
            if (start_s) begin
                addr_r    <= base_addr;
                count_r   <= '0;
                acc_r     <= '0;
                err_ill_r <= 1'b0;
            end else begin
                if (drain_s) begin
                    addr_r  <= addr_r + 1'b1;
                    count_r <= count_r + ONE_C;
                end
                if (accept_s)              acc_r     <= acc_r + ONE_C;
                if (accept_s && illegal_s) err_ill_r <= 1'b1;
            end
            if (keep_s) begin
                wr_valid_r <= 1'b1;
                wr_data_r  <= word_s;
            end else if (drain_s) begin
                wr_valid_r <= 1'b0;
            end
        end
    end

`ifdef ENCODER_IMM_CHECK_EN
    logic err_imm_r;

    // Sticky bad-immediate flag, cleared at session start.
    always_ff @(posedge clk) begin
        if (rst)                               err_imm_r <= 1'b0;
        else if (start_s)                      err_imm_r <= 1'b0;
        else if (accept_s && imm_bad_s && !illegal_s) err_imm_r <= 1'b1;
    end

    assign err_imm = err_imm_r;
`else
    assign err_imm = 1'b0;
`endif

    assign bus.req_ready = req_ready_s;
    assign bus.wr_valid  = wr_valid_r;
    assign bus.wr_addr   = addr_r;
    assign bus.wr_data   = wr_data_r;
    assign word_count    = count_r;
    assign done          = (state_r == ST_DONE);
    assign err_illegal   = err_ill_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed known-answer steps then randomized
// sessions, all checked against a behavioural model of the loader session.
module tb_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              finish = 1'b0;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              err_illegal;
    logic              err_imm;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .finish      (finish),
        .bus         (bus),
        .word_count  (word_count),
        .done        (done),
        .err_illegal (err_illegal),
        .err_imm     (err_imm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: 0 idle, 1 run, 2 drain, 3 done
    int          m_st = 0;
    int          m_acc = 0;
    int          m_wc = 0;
    logic [7:0]  m_addr = 8'h00;
    bit          m_wv = 1'b0;
    bit          m_eil = 1'b0;
    bit          m_eim = 1'b0;
    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                               input int rs2, input logic [12:0] imm);
        logic [31:0] u;
        int f3;
        int f7;
        u = 32'(imm);
        if (op <= 3) begin
            f7 = (op == 1) ? 32 : 0;
            f3 = (op == 2) ? 7 : (op == 3) ? 6 : 0;
            return 32'(f7 * (2**25) + rs2 * (2**20) + rs1 * (2**15) + f3 * (2**12) +
                       rd * (2**7) + 51);
        end else if (op == 4) begin
            return ((u & 32'hFFF) << 20) | 32'(rs1 << 15) | 32'(3 << 12) | 32'(rd << 7) | 32'd3;
        end else if (op == 5) begin
            return (((u >> 5) & 32'h7F) << 25) | 32'(rs2 << 20) | 32'(rs1 << 15) |
                   32'(3 << 12) | ((u & 32'h1F) << 7) | 32'd35;
        end else begin
            return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                   32'(rs2 << 20) | 32'(rs1 << 15) | (((u >> 1) & 32'hF) << 8) |
                   (((u >> 11) & 32'h1) << 7) | 32'd99;
        end
    endfunction

    function automatic bit ref_imm_bad(input int op, input logic [12:0] imm);
`ifdef ENCODER_IMM_CHECK_EN
        int sv;
        sv = int'($signed(imm));
        if (op == 4 || op == 5) return (sv < -2048) || (sv > 2047);
        if (op == 6) return (sv % 2) != 0;
        return 1'b0;
`else
        return (op < 0) && (imm == 13'd0);
`endif
    endfunction

    task automatic tick();
        bit exp_rr;
        bit acc;
        bit wh;
        bit old_wv;
        int op;
        #2;
        exp_rr = (m_st == 1) && (!m_wv || bus.wr_ready) && (m_acc < DEPTH);
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rr));
            chk("wr_valid", 32'(bus.wr_valid), 32'(m_wv));
            chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
            chk("word_count", 32'(word_count), 32'(m_wc));
            chk("done", 32'(done), 32'(m_st == 3));
            chk("err_illegal", 32'(err_illegal), 32'(m_eil));
            chk("err_imm", 32'(err_imm), 32'(m_eim));
            if (m_wv && q.size() > 0) chk("wr_data", bus.wr_data, q[0]);
        end
        acc = bus.req_valid && exp_rr && !rst;
        wh  = m_wv && bus.wr_ready;
        op  = int'(bus.req_op);
        @(posedge clk);
        #1;
        if (rst) begin
            m_st = 0; m_acc = 0; m_wc = 0; m_addr = 8'h00;
            m_wv = 1'b0; m_eil = 1'b0; m_eim = 1'b0;
            q.delete();
        end else begin
            old_wv = m_wv;
            if (wh) begin
                m_addr = m_addr + 8'd1;
                m_wc++;
                void'(q.pop_front());
                m_wv = 1'b0;
            end
            if (acc) begin
                m_acc++;
                if (op == 7) m_eil = 1'b1;
                else if (ref_imm_bad(op, bus.req_imm)) m_eim = 1'b1;
                else begin
                    q.push_back(ref_encode(op, int'(bus.req_rd), int'(bus.req_rs1),
                                           int'(bus.req_rs2), bus.req_imm));
                    m_wv = 1'b1;
                end
            end
            if (m_st == 0 || m_st == 3) begin
                if (start) begin
                    m_st = 1; m_acc = 0; m_wc = 0; m_addr = base_addr;
                    m_eil = 1'b0; m_eim = 1'b0;
                end
            end else if (m_st == 1) begin
                if (finish || (acc && m_acc == DEPTH)) m_st = 2;
            end else if (m_st == 2) begin
                if (!old_wv) m_st = 3;
            end
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm);
        bus.req_op  = op;
        bus.req_rd  = rd;
        bus.req_rs1 = rs1;
        bus.req_rs2 = rs2;
        bus.req_imm = imm;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic begin_session(input logic [7:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic end_session();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = 3'd0; bus.req_rd = 5'd0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0;
        bus.req_imm = 13'd0;
        bus.wr_ready = 1'b1;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_wr_data", bus.wr_data, 32'h0000_0000);
        chk("reset_done", 32'(done), 32'd0);
        tick();

        // Session 1: known-answer words, auto-DONE after DEPTH accepts
        begin_session(8'h10);
        send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        chk("kat_add", bus.wr_data, 32'h002081B3);
        chk("kat_add_addr", 32'(bus.wr_addr), 32'h10);
        send(3'd1, 5'd3, 5'd1, 5'd2, 13'd0);
        chk("kat_sub", bus.wr_data, 32'h402081B3);
        chk("kat_sub_addr", 32'(bus.wr_addr), 32'h11);
        send(3'd4, 5'd5, 5'd2, 5'd0, 13'd8);
        chk("kat_ld", bus.wr_data, 32'h00813283);
        chk("kat_ld_addr", 32'(bus.wr_addr), 32'h12);
        send(3'd5, 5'd0, 5'd2, 5'd5, 13'd16);
        chk("kat_sd", bus.wr_data, 32'h00513823);
        repeat (3) tick();
        chk("depth_done", 32'(done), 32'd1);
        chk("depth_count", 32'(word_count), 32'd4);

        // Session 2: BEQ then a 5-cycle write stall
        begin_session(8'h20);
        bus.wr_ready = 1'b0;
        send(3'd6, 5'd0, 5'd1, 5'd2, 13'h1FFC);
        chk("kat_beq", bus.wr_data, 32'hFE208EE3);
        bus.req_op = 3'd2; bus.req_rd = 5'd7; bus.req_rs1 = 5'd8; bus.req_rs2 = 5'd9;
        bus.req_valid = 1'b1;
        repeat (5) tick();
        chk("stall_data", bus.wr_data, 32'hFE208EE3);
        chk("stall_addr", 32'(bus.wr_addr), 32'h20);
        bus.wr_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("after_stall_and", bus.wr_data, 32'h009473B3);
        chk("after_stall_addr", 32'(bus.wr_addr), 32'h21);
        end_session();
        chk("stall_count", 32'(word_count), 32'd2);

        // Session 3: illegal op dropped; LD with out-of-range immediate
        begin_session(8'h30);
        send(3'd7, 5'd1, 5'd1, 5'd1, 13'd0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        chk("illegal_flag", 32'(err_illegal), 32'd1);
        chk("illegal_addr", 32'(bus.wr_addr), 32'h30);
        chk("illegal_next", bus.wr_data, 32'h002081B3);
        send(3'd4, 5'd5, 5'd2, 5'd0, 13'h1000);
        end_session();
`ifdef ENCODER_IMM_CHECK_EN
        chk("imm_flag", 32'(err_imm), 32'd1);
        chk("imm_count", 32'(word_count), 32'd1);
`else
        chk("imm_flag", 32'(err_imm), 32'd0);
        chk("imm_count", 32'(word_count), 32'd2);
`endif

        // Session 4: address wrap 0xFE..0x01, auto DONE
        begin_session(8'hFE);
        for (int i = 0; i < 4; i++) send(3'd3, 5'(i), 5'd4, 5'd6, 13'd0);
        chk("wrap_last_addr", 32'(bus.wr_addr), 32'h01);
        repeat (3) tick();
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_addr", 32'(bus.wr_addr), 32'h02);

        // Reset while a word is pending
        begin_session(8'h40);
        bus.wr_ready = 1'b0;
        send(3'd0, 5'd1, 5'd2, 5'd3, 13'd0);
        chk("pending_valid", 32'(bus.wr_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.wr_ready = 1'b1;
        chk("rst_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_addr", 32'(bus.wr_addr), 32'd0);
        tick();

        // Randomized sessions
        for (int s = 0; s < 40; s++) begin
            begin_session(8'($urandom_range(0, 255)));
            for (int c = 0; c < 30; c++) begin
                bus.req_valid = ($urandom_range(0, 3) != 0);
                bus.req_op    = 3'($urandom_range(0, 7));
                bus.req_rd    = 5'($urandom);
                bus.req_rs1   = 5'($urandom);
                bus.req_rs2   = 5'($urandom);
                bus.req_imm   = 13'($urandom);
                bus.wr_ready  = ($urandom_range(0, 2) != 0);
                finish        = ($urandom_range(0, 19) == 0);
                start         = ($urandom_range(0, 9) == 0);
                base_addr     = 8'($urandom);
                rst           = ($urandom_range(0, 149) == 0);
                tick();
            end
            bus.req_valid = 1'b0;
            start = 1'b0;
            rst = 1'b0;
            bus.wr_ready = 1'b1;
            end_session();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
